// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StHold = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INC      = 32'd4;
  localparam logic [31:0] DEFAULT_NOP = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: redirect/flush kill it, stall holds it, otherwise it loads or empties.
module if_id_reg
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INST = DEFAULT_NOP
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect,
  input  logic        i_flush,
  input  logic        i_hold,
  input  logic        i_load,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4
);

  logic        r_valid;
  logic [31:0] r_inst;
  logic [31:0] r_pc;
  logic [31:0] r_pc_plus4;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_valid    <= 1'b0;
      r_inst     <= NOP_INST;
      r_pc       <= 32'h0;
      r_pc_plus4 <= 32'h0;
    end else if (i_redirect || i_flush) begin
      r_valid <= 1'b0;
      r_inst  <= NOP_INST;
    end else if (!i_hold) begin
      if (i_load) begin
        r_valid    <= 1'b1;
        r_inst     <= i_inst;
        r_pc       <= i_pc;
        r_pc_plus4 <= i_pc + PC_INC;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_inst     = r_inst;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, req/ack fetch FSM, redirect kill logic, hold buffer and IF/ID.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_fetch_stage
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_id_valid,
  output logic [31:0] o_id_inst,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_pc_plus4,
  output logic        o_fetch_busy
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] o_perf_fetch_cnt,
  output logic [31:0] o_perf_stall_cnt
`endif
);

  fetch_state_e r_state;
  logic         r_req;
  logic [31:0]  r_pc;
  logic         r_kill;
  logic [31:0]  r_kill_pc;
  logic [31:0]  r_hold_inst;
  logic [31:0]  r_hold_pc;

  logic         w_fire;
  logic [31:0]  w_target;
  logic         w_id_valid;
  logic         w_id_hold;
  logic         w_load;
  logic [31:0]  w_load_inst;
  logic [31:0]  w_load_pc;

  assign w_fire    = r_req & i_imem_ack;
  assign w_target  = align_pc(i_redirect_pc);
  // Stalling an empty IF/ID is meaningless, so it only holds when it contains something.
  assign w_id_hold = i_stall & w_id_valid;

  always_comb begin
    w_load      = 1'b0;
    w_load_inst = i_imem_rdata;
    w_load_pc   = r_pc;
    case (r_state)
      StReq: begin
        w_load = w_fire & ~i_redirect & ~r_kill & ~w_id_hold;
      end
      StHold: begin
        w_load      = ~i_redirect & ~i_stall;
        w_load_inst = r_hold_inst;
        w_load_pc   = r_hold_pc;
      end
      default: w_load = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= StIdle;
      r_req       <= 1'b0;
      r_pc        <= RESET_PC;
      r_kill      <= 1'b0;
      r_kill_pc   <= 32'h0;
      r_hold_inst <= NOP_INST;
      r_hold_pc   <= 32'h0;
    end else begin
      case (r_state)
        StIdle: begin
          r_state <= StReq;
          r_req   <= 1'b1;
          if (i_redirect) r_pc <= w_target;
        end
        StReq: begin
          if (i_redirect) begin
            // The in-flight address must stay stable, so defer the target until the ack.
            if (w_fire) begin
              r_pc   <= w_target;
              r_kill <= 1'b0;
            end else begin
              r_kill    <= 1'b1;
              r_kill_pc <= w_target;
            end
          end else if (w_fire) begin
            if (r_kill) begin
              r_pc   <= r_kill_pc;
              r_kill <= 1'b0;
            end else begin
              r_pc <= r_pc + PC_INC;
              if (w_id_hold) begin
                r_hold_inst <= i_imem_rdata;
                r_hold_pc   <= r_pc;
                r_state     <= StHold;
                r_req       <= 1'b0;
              end
            end
          end
        end
        StHold: begin
          if (i_redirect) begin
            r_pc    <= w_target;
            r_state <= StReq;
            r_req   <= 1'b1;
          end else if (!i_stall) begin
            r_state <= StReq;
            r_req   <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_redirect (i_redirect),
    .i_flush    (i_flush),
    .i_hold     (w_id_hold),
    .i_load     (w_load),
    .i_inst     (w_load_inst),
    .i_pc       (w_load_pc),
    .o_valid    (w_id_valid),
    .o_inst     (o_id_inst),
    .o_pc       (o_id_pc),
    .o_pc_plus4 (o_id_pc_plus4)
  );

  assign o_id_valid   = w_id_valid;
  assign o_imem_req   = r_req;
  assign o_imem_addr  = r_pc;
  assign o_fetch_busy = (r_state == StReq);

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_perf_fetch_cnt <= 32'h0;
      r_perf_stall_cnt <= 32'h0;
    end else begin
      if (w_load && !i_flush) r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      if (w_id_hold)          r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
    end
  end

  assign o_perf_fetch_cnt = r_perf_fetch_cnt;
  assign o_perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage; counter checks appear with IF_PERF_CNT_EN.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fetch_busy;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  logic        ovr_en;
  logic [31:0] ovr_data;
  int          n_checks;
  int          n_errors;
  int          exp_fetch;
  int          exp_stall;

  // Memory model: instruction word tagged with its own address unless overridden.
  assign imem_rdata = ovr_en ? ovr_data : (32'h1000_0000 | imem_addr);

  if_fetch_stage u_dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_ack    (imem_ack),
    .i_imem_rdata  (imem_rdata),
    .i_stall       (stall),
    .i_flush       (flush),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_id_valid    (id_valid),
    .o_id_inst     (id_inst),
    .o_id_pc       (id_pc),
    .o_id_pc_plus4 (id_pc_plus4),
    .o_fetch_busy  (fetch_busy)
`ifdef IF_PERF_CNT_EN
    ,
    .o_perf_fetch_cnt (perf_fetch_cnt),
    .o_perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_perf(input string tag);
`ifdef IF_PERF_CNT_EN
    check_eq({tag, "_fetch_cnt"}, perf_fetch_cnt, exp_fetch);
    check_eq({tag, "_stall_cnt"}, perf_stall_cnt, exp_stall);
`else
    if (tag.len() == 0) $display("perf counters absent");
`endif
  endtask

  initial begin
    n_checks = 0; n_errors = 0; exp_fetch = 0; exp_stall = 0;
    rst = 1'b0; imem_ack = 1'b0; stall = 1'b0; flush = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0; ovr_en = 1'b0; ovr_data = 32'h0;

    // Reset state
    #2;
    check_eq("rst_req", imem_req, 32'd0);
    check_eq("rst_valid", id_valid, 32'd0);
    check_eq("rst_inst", id_inst, 32'h0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_busy", fetch_busy, 32'd0);
    rst = 1'b1;
    tick();
    check_eq("start_req", imem_req, 32'd1);
    check_eq("start_addr", imem_addr, 32'h0);
    check_eq("start_busy", fetch_busy, 32'd1);

    // Zero-wait streaming
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_fetch++;
      check_eq("stream_pc", id_pc, 32'(i * 4));
      check_eq("stream_pc4", id_pc_plus4, 32'(i * 4 + 4));
      check_eq("stream_inst", id_inst, 32'h1000_0000 | 32'(i * 4));
      check_eq("stream_valid", id_valid, 32'd1);
    end
    check_perf("stream");

    // Ack while stalled goes to HOLD
    stall = 1'b1; ovr_en = 1'b1; ovr_data = 32'h2002_0005;
    tick();
    exp_stall++;
    imem_ack = 1'b0; ovr_en = 1'b0;
    check_eq("hold_req", imem_req, 32'd0);
    check_eq("hold_busy", fetch_busy, 32'd0);
    check_eq("hold_id_pc", id_pc, 32'h8);
    check_eq("hold_id_inst", id_inst, 32'h1000_0008);
    tick();
    exp_stall++;
    check_eq("hold2_req", imem_req, 32'd0);
    check_eq("hold2_id_pc", id_pc, 32'h8);
    stall = 1'b0;
    tick();
    exp_fetch++;
    check_eq("unhold_inst", id_inst, 32'h2002_0005);
    check_eq("unhold_pc", id_pc, 32'hC);
    check_eq("unhold_valid", id_valid, 32'd1);
    check_eq("unhold_req", imem_req, 32'd1);
    check_eq("unhold_addr", imem_addr, 32'h10);
    check_perf("hold");

    // Redirect during wait cycles: address stays put, fetched word discarded
    redirect = 1'b1; redirect_pc = 32'h40;
    for (int i = 0; i < 3; i++) begin
      tick();
      redirect = 1'b0;
      check_eq("kill_addr", imem_addr, 32'h10);
      check_eq("kill_req", imem_req, 32'd1);
      check_eq("kill_valid", id_valid, 32'd0);
    end
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check_eq("kill_done_valid", id_valid, 32'd0);
    check_eq("kill_done_addr", imem_addr, 32'h40);

    // Flush beats stall; same-cycle redirect+ack with unaligned target
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    exp_fetch++;
    check_eq("pre_flush_pc", id_pc, 32'h40);
    check_eq("pre_flush_valid", id_valid, 32'd1);
    flush = 1'b1; stall = 1'b1;
    tick();
    exp_stall++;
    flush = 1'b0; stall = 1'b0;
    check_eq("flush_valid", id_valid, 32'd0);
    check_eq("flush_inst", id_inst, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h43; imem_ack = 1'b1;
    tick();
    redirect = 1'b0; imem_ack = 1'b0;
    check_eq("redir_ack_addr", imem_addr, 32'h40);
    check_eq("redir_ack_valid", id_valid, 32'd0);
    check_perf("flush");

    // Two redirects while a fetch is pending: latest wins
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0; imem_ack = 1'b1;
    check_eq("redir2_addr_held", imem_addr, 32'h40);
    tick();
    imem_ack = 1'b0;
    check_eq("redir2_addr", imem_addr, 32'h200);
    check_eq("redir2_valid", id_valid, 32'd0);

    // PC wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_ack = 1'b1;
    tick();
    redirect = 1'b0;
    check_eq("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    exp_fetch++;
    check_eq("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
    check_eq("wrap_pc4", id_pc_plus4, 32'h0);
    check_eq("wrap_inst", id_inst, 32'hFFFF_FFFC);
    check_eq("wrap_next_addr", imem_addr, 32'h0);
    check_perf("wrap");

    // Asynchronous reset mid-transaction drops the request at once
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_req", imem_req, 32'd0);
    check_eq("arst_valid", id_valid, 32'd0);
    check_eq("arst_addr", imem_addr, 32'h0);
    check_eq("arst_busy", fetch_busy, 32'd0);
    exp_fetch = 0; exp_stall = 0;
    check_perf("arst");
    imem_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
